cam_pattern_gen: RTL and testbench
==================================

Name: cam_pattern_gen

Overview:
- Synthesizable OV7670-style camera stream transmitter: the source end of the PCLK/VSYNC/HREF/D[7:0] interface that cam_read receives.
- Generates QQVGA RGB444 frames (2 bytes per pixel) from built-in test patterns.
- Substitutes for the physical camera in simulation and on-board bring-up. Its outputs drive cam_read and buffer_ram_dp clk_w directly.

Parameters:
- H_ACTIVE, 160, pixels per line.
- V_ACTIVE, 120, lines per frame.
- H_BLANK, 16, PCLK cycles with HREF low between lines.
- V_FRONT, 10, PCLK cycles after the last line's blank before VSYNC.
- VSYNC_LEN, 4, PCLK cycles VSYNC high.
- V_BACK, 10, PCLK cycles after VSYNC falls before line 0.
- SOLID_COLOR, 12'h0F0, RGB444 value for mode 3.

Ports:
- clk  in  1  system clock; byte rate is clk/2.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  stream enable.
- mode  in  2  pattern select, sampled at frame start.
- CAM_pclk  out  1  pixel clock, clk/2.
- CAM_vsync  out  1  frame sync, active high.
- CAM_href  out  1  line valid, active high.
- CAM_D  out  8  pixel data byte.
- frame_done  out  1  one-clk pulse at end of frame.

Behaviour:
- Reset (rst=0, async): CAM_pclk=0, CAM_vsync=0, CAM_href=0, CAM_D=8'h00, frame_done=0. FSM goes to IDLE and all counters clear.
- PCLK generation: CAM_pclk toggles every clk once rst=1, including in IDLE.
- Update edge: every other output and the FSM change only on the clk edge where CAM_pclk goes 1->0 (the "update edge"). All outputs are therefore stable across the PCLK rising edge that the receiver samples on.
- FSM states: IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT. A cycle count n means n PCLK periods.
  - IDLE: all sync outputs low. On an update edge with en=1: latch mode, x=0, y=0, go to VSYNC.
  - VSYNC: CAM_vsync=1 for VSYNC_LEN cycles, then VBACK.
  - VBACK: outputs low for V_BACK cycles, then LINE.
  - LINE: CAM_href=1 for 2*H_ACTIVE cycles.
    - Even byte = {4'h0, R}. Odd byte = {G, B}. Pixel is {R, G, B} = pat(x, y).
    - x increments after each odd byte.
    - Afterwards: HREF low, CAM_D=0, go to HBLANK.
  - HBLANK: lasts H_BLANK cycles. Then y+1; if y+1 == V_ACTIVE go to VFRONT, else x=0 and go to LINE.
  - VFRONT: lasts V_FRONT cycles. At its final update edge frame_done=1 for exactly one clk. Then go to VSYNC if en=1, else IDLE.
- Enable rules:
  - Dropping en mid-frame has no effect until the frame completes; frames are never truncated.
  - en re-asserted in IDLE starts the next frame at the next update edge.
- Frame timing: total PCLK cycles per frame (continuous en) = VSYNC_LEN + V_BACK + V_ACTIVE*(2*H_ACTIVE + H_BLANK) + V_FRONT. With defaults this is 40344.
- Patterns (mode latched per frame; changes mid-frame are ignored):
  - 0: incrementing, pat = (x + y) mod 4096 (12-bit wrap).
  - 1: colour bars, index = (x*8)/H_ACTIVE. Colours FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 2: checkerboard, pat = (x[3]^y[3]) ? 12'hFFF : 12'h000.
  - 3: SOLID_COLOR.
- Widths: x and y counters are $clog2 of H_ACTIVE and V_ACTIVE plus 1 bit. Blank counters are sized to the largest of the blank/sync parameters.
- Reset mid-frame: all outputs return to reset values immediately (async). After release the generator restarts from IDLE; there is no partial-frame resume.

Optional Feature:
- Macro: CAM_PATTERN_FRAME_CNT_EN.
- Defined: a 12-bit frame counter increments on each frame_done and clears on reset. Mode 0 becomes pat = (x + y + frame_cnt) mod 4096, so consecutive frames differ and the bench can detect dropped or stale frames in buffer_ram_dp.
- Undefined: no counter logic is built and mode 0 is exactly (x + y) mod 4096.

Test Plan:
- Reset then en=1, mode=3, SOLID_COLOR=12'h0F0 -> CAM_vsync high for 4 PCLK periods. First HREF rises 10 PCLK periods after VSYNC falls. Each line carries 320 bytes alternating 8'h00 / 8'hF0. HREF is high 120 times per frame.
- mode=0, capture frame 0 -> pixel (x=5, y=3) bytes are 8'h00, 8'h08. Pixel (159, 119) bytes are 8'h01, 8'h16. frame_done pulses once, 40344 PCLK periods after the first VSYNC rise.
- mode=1 -> pixel x=0 is FFF, x=20 is FF0, x=159 is 000. mode switched to 2 mid-frame -> takes effect only after the next VSYNC.
- en dropped during line 60 -> the frame completes through VFRONT, frame_done pulses, then IDLE with VSYNC and HREF low. en=1 again -> VSYNC rises at the next update edge.
- rst asserted during LINE -> all outputs 0 in the same clk period without waiting for a clock edge. After release, CAM_vsync stays 0 until en is sampled.
- With CAM_PATTERN_FRAME_CNT_EN, mode=0 -> pixel (0,0) equals 12'h000 in frame 0, 12'h001 in frame 1, 12'h002 in frame 2. The same bench with the macro undefined -> 12'h000 in every frame.

Source files
------------

// File: rtl/cam_pattern_gen.sv
// OV7670-style QQVGA RGB444 test-pattern source; CAM_PATTERN_FRAME_CNT_EN adds a frame counter to mode 0.
// Outputs registered, updated only as CAM_pclk falls; no backpressure, en only gates the start of the next frame.
module cam_pattern_gen #(
    parameter int          H_ACTIVE    = 160,
    parameter int          V_ACTIVE    = 120,
    parameter int          H_BLANK     = 16,
    parameter int          V_FRONT     = 10,
    parameter int          VSYNC_LEN   = 4,
    parameter int          V_BACK      = 10,
    parameter logic [11:0] SOLID_COLOR = 12'h0F0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       CAM_pclk,
    output logic       CAM_vsync,
    output logic       CAM_href,
    output logic [7:0] CAM_D,
    output logic       frame_done
);
    localparam int XW   = $clog2(H_ACTIVE) + 1;
    localparam int YW   = $clog2(V_ACTIVE) + 1;
    localparam int MX_A = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int MX_B = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
    localparam int BMAX = (MX_A > MX_B) ? MX_A : MX_B;
    localparam int CW   = $clog2(BMAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        LINE   = 3'd3,
        HBLANK = 3'd4,
        VFRONT = 3'd5
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            phase;
    logic [1:0]      mode_q;
    logic [XW-1:0]   nx;
    logic [YW-1:0]   ny;
    logic [2:0]      bar_idx;
    logic [11:0]     pix;
`ifdef CAM_PATTERN_FRAME_CNT_EN
    logic [11:0]     frame_cnt;
`endif

    // Coordinates of the pixel whose byte goes out at the coming update edge.
    always_comb begin
        nx = x;
        ny = y;
        case (state)
            VBACK: begin
                nx = '0;
                ny = '0;
            end
            HBLANK: begin
                nx = '0;
                ny = y + YW'(1);
            end
            LINE: begin
                if (phase) nx = x + XW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        pix     = 12'h000;
        bar_idx = 3'((int'(nx) * 8) / H_ACTIVE);
        case (mode_q)
            2'd0: begin
`ifdef CAM_PATTERN_FRAME_CNT_EN
                pix = 12'(nx) + 12'(ny) + frame_cnt;
`else
                pix = 12'(nx) + 12'(ny);
`endif
            end
            2'd1: begin
                case (bar_idx)
                    3'd0: pix = 12'hFFF;
                    3'd1: pix = 12'hFF0;
                    3'd2: pix = 12'h0FF;
                    3'd3: pix = 12'h0F0;
                    3'd4: pix = 12'hF0F;
                    3'd5: pix = 12'hF00;
                    3'd6: pix = 12'h00F;
                    default: pix = 12'h000;
                endcase
            end
            2'd2: pix = (nx[3] ^ ny[3]) ? 12'hFFF : 12'h000;
            default: pix = SOLID_COLOR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            mode_q     <= 2'd0;
            CAM_pclk   <= 1'b0;
            CAM_vsync  <= 1'b0;
            CAM_href   <= 1'b0;
            CAM_D      <= 8'h00;
            frame_done <= 1'b0;
`ifdef CAM_PATTERN_FRAME_CNT_EN
            frame_cnt  <= 12'h000;
`endif
        end else begin
            CAM_pclk   <= ~CAM_pclk;
            frame_done <= 1'b0;
            // CAM_pclk high now means this edge drives it low: the update edge.
            if (CAM_pclk) begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            mode_q    <= mode;
                            x         <= '0;
                            y         <= '0;
                            cnt       <= '0;
                            CAM_vsync <= 1'b1;
                            state     <= VSYNC;
                        end
                    end
                    VSYNC: begin
                        if (cnt == CW'(VSYNC_LEN - 1)) begin
                            cnt       <= '0;
                            CAM_vsync <= 1'b0;
                            state     <= VBACK;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    VBACK: begin
                        if (cnt == CW'(V_BACK - 1)) begin
                            cnt      <= '0;
                            x        <= '0;
                            phase    <= 1'b0;
                            CAM_href <= 1'b1;
                            CAM_D    <= {4'h0, pix[11:8]};
                            state    <= LINE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    LINE: begin
                        if (!phase) begin
                            CAM_D <= pix[7:0];
                            phase <= 1'b1;
                        end else if (x == XW'(H_ACTIVE - 1)) begin
                            CAM_href <= 1'b0;
                            CAM_D    <= 8'h00;
                            cnt      <= '0;
                            state    <= HBLANK;
                        end else begin
                            x     <= x + XW'(1);
                            phase <= 1'b0;
                            CAM_D <= {4'h0, pix[11:8]};
                        end
                    end
                    HBLANK: begin
                        if (cnt == CW'(H_BLANK - 1)) begin
                            cnt <= '0;
                            if (y == YW'(V_ACTIVE - 1)) begin
                                state <= VFRONT;
                            end else begin
                                y        <= y + YW'(1);
                                x        <= '0;
                                phase    <= 1'b0;
                                CAM_href <= 1'b1;
                                CAM_D    <= {4'h0, pix[11:8]};
                                state    <= LINE;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    VFRONT: begin
                        if (cnt == CW'(V_FRONT - 1)) begin
                            cnt        <= '0;
                            frame_done <= 1'b1;
`ifdef CAM_PATTERN_FRAME_CNT_EN
                            frame_cnt  <= frame_cnt + 12'h001;
`endif
                            if (en) begin
                                mode_q    <= mode;
                                x         <= '0;
                                y         <= '0;
                                CAM_vsync <= 1'b1;
                                state     <= VSYNC;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_pattern_gen.sv
// Directed bench for cam_pattern_gen using a short frame (10 lines) so several frames fit in the run.
module tb_cam_pattern_gen;
    localparam int TB_H    = 160;
    localparam int TB_V    = 10;
    localparam int FRAME_P = 4 + 10 + TB_V * (2 * TB_H + 16) + 10;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       CAM_pclk;
    logic       CAM_vsync;
    logic       CAM_href;
    logic [7:0] CAM_D;
    logic       frame_done;

    int tests_run;
    int tests_failed;
    int fc_model;

    logic [7:0]  fb [0:TB_V*2*TB_H-1];
    bit          cap_timeout;
    int          cap_vs_len, cap_gap, cap_lines, cap_badlines, cap_periods, cap_fd_clks;
    logic [11:0] cap_fc_off;

    cam_pattern_gen #(
        .H_ACTIVE(TB_H), .V_ACTIVE(TB_V), .H_BLANK(16), .V_FRONT(10),
        .VSYNC_LEN(4), .V_BACK(10), .SOLID_COLOR(12'h0F0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
        .CAM_D(CAM_D), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next negedge where CAM_pclk is high; counts frame_done clocks on the way.
    task automatic pstep(output int fd_clks);
        int g;
        fd_clks = 0;
        g = 0;
        @(negedge clk);
        if (frame_done === 1'b1) fd_clks++;
        while (CAM_pclk !== 1'b1 && g < 3) begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_clks++;
            g++;
        end
    endtask

    function automatic logic [15:0] pix_bytes(input int px, input int py);
        return {fb[py*2*TB_H + 2*px], fb[py*2*TB_H + 2*px + 1]};
    endfunction

    task automatic capture_frame(input logic [1:0] next_mode, input bit drop_en);
        int g, fdc, bcnt;
        bit done, prev_href, vs_phase;
        g = 0;
        fdc = 0;
        while (CAM_vsync !== 1'b1 && g < 400) begin
            pstep(fdc);
            g++;
        end
        cap_timeout = (CAM_vsync !== 1'b1);
        cap_vs_len = 1; cap_gap = 0; cap_lines = 0; cap_badlines = 0;
        cap_periods = 0; cap_fd_clks = 0;
`ifdef CAM_PATTERN_FRAME_CNT_EN
        cap_fc_off = 12'(fc_model);
`else
        cap_fc_off = 12'h000;
`endif
        done = 0; prev_href = 0; vs_phase = 1; bcnt = 0;
        while (!done && !cap_timeout) begin
            pstep(fdc);
            cap_periods++;
            if (fdc != 0) begin
                done = 1;
                cap_fd_clks = fdc;
                fc_model++;
            end else begin
                if (vs_phase && CAM_vsync === 1'b1) cap_vs_len++;
                else vs_phase = 0;
                if (!vs_phase && cap_lines == 0 && CAM_href !== 1'b1) cap_gap++;
                if (CAM_href === 1'b1) begin
                    if (!prev_href) begin
                        cap_lines++;
                        bcnt = 0;
                    end
                    if (cap_lines <= TB_V && bcnt < 2*TB_H) fb[(cap_lines-1)*2*TB_H + bcnt] = CAM_D;
                    bcnt++;
                    if (cap_lines == TB_V/2 + 1 && bcnt == 100) begin
                        mode = next_mode;
                        if (drop_en) en = 1'b0;
                    end
                end else if (prev_href) begin
                    if (bcnt != 2*TB_H) cap_badlines++;
                end
                prev_href = (CAM_href === 1'b1);
            end
            if (cap_periods > FRAME_P + 100) cap_timeout = 1;
        end
    endtask

    task automatic test_reset;
        int toggles, vs_bad;
        logic prev;
        rst = 1'b0; en = 1'b0; mode = 2'd0; fc_model = 0;
        repeat (3) @(negedge clk);
        tests_run++; if (CAM_pclk !== 1'b0) begin tests_failed++; $display("FAIL rst_pclk got %b want 0", CAM_pclk); end
        tests_run++; if (CAM_vsync !== 1'b0) begin tests_failed++; $display("FAIL rst_vsync got %b want 0", CAM_vsync); end
        tests_run++; if (CAM_href !== 1'b0) begin tests_failed++; $display("FAIL rst_href got %b want 0", CAM_href); end
        tests_run++; if (CAM_D !== 8'h00) begin tests_failed++; $display("FAIL rst_data got %h want 00", CAM_D); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        rst = 1'b1;
        toggles = 0; vs_bad = 0;
        @(negedge clk);
        prev = CAM_pclk;
        repeat (8) begin
            @(negedge clk);
            if (CAM_pclk !== prev) toggles++;
            if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0) vs_bad++;
            prev = CAM_pclk;
        end
        tests_run++; if (toggles != 8) begin tests_failed++; $display("FAIL idle_pclk_toggles got %0d want 8", toggles); end
        tests_run++; if (vs_bad != 0) begin tests_failed++; $display("FAIL idle_sync_low got %0d bad samples want 0", vs_bad); end
    endtask

    task automatic test_solid;
        int bad;
        mode = 2'd3;
        en = 1'b1;
        capture_frame(2'd0, 1'b0);
        tests_run++; if (cap_timeout) begin tests_failed++; $display("FAIL solid_timeout got timeout want frame"); end
        tests_run++; if (cap_vs_len != 4) begin tests_failed++; $display("FAIL vsync_len got %0d want 4", cap_vs_len); end
        tests_run++; if (cap_gap != 10) begin tests_failed++; $display("FAIL vback_len got %0d want 10", cap_gap); end
        tests_run++; if (cap_lines != TB_V) begin tests_failed++; $display("FAIL href_count got %0d want %0d", cap_lines, TB_V); end
        tests_run++; if (cap_badlines != 0) begin tests_failed++; $display("FAIL line_bytes got %0d short/long lines want 0", cap_badlines); end
        tests_run++; if (cap_periods != FRAME_P) begin tests_failed++; $display("FAIL frame_period got %0d want %0d", cap_periods, FRAME_P); end
        tests_run++; if (cap_fd_clks != 1) begin tests_failed++; $display("FAIL frame_done_width got %0d want 1", cap_fd_clks); end
        bad = 0;
        for (int i = 0; i < TB_V*2*TB_H; i++)
            if (fb[i] !== (((i % 2) == 0) ? 8'h00 : 8'hF0)) bad++;
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL solid_bytes got %0d wrong bytes want 0", bad); end
    endtask

    task automatic test_incr;
        logic [15:0] exp;
        capture_frame(2'd0, 1'b0);
        exp = {4'h0, 12'h008 + cap_fc_off};
        tests_run++; if (pix_bytes(5, 3) !== exp) begin tests_failed++; $display("FAIL incr_5_3 got %h want %h", pix_bytes(5, 3), exp); end
        exp = {4'h0, 12'h0A8 + cap_fc_off};
        tests_run++; if (pix_bytes(159, 9) !== exp) begin tests_failed++; $display("FAIL incr_159_9 got %h want %h", pix_bytes(159, 9), exp); end
        tests_run++; if (cap_periods != FRAME_P) begin tests_failed++; $display("FAIL incr_period got %0d want %0d", cap_periods, FRAME_P); end
        capture_frame(2'd1, 1'b0);
        exp = {4'h0, cap_fc_off};
        tests_run++; if (pix_bytes(0, 0) !== exp) begin tests_failed++; $display("FAIL incr_0_0 got %h want %h", pix_bytes(0, 0), exp); end
        exp = {4'h0, 12'h002 + cap_fc_off};
        tests_run++; if (pix_bytes(1, 1) !== exp) begin tests_failed++; $display("FAIL incr_1_1 got %h want %h", pix_bytes(1, 1), exp); end
    endtask

    task automatic test_bars;
        capture_frame(2'd2, 1'b0);
        tests_run++; if (pix_bytes(0, 0) !== 16'h0FFF) begin tests_failed++; $display("FAIL bar_x0 got %h want 0fff", pix_bytes(0, 0)); end
        tests_run++; if (pix_bytes(20, 2) !== 16'h0FF0) begin tests_failed++; $display("FAIL bar_x20 got %h want 0ff0", pix_bytes(20, 2)); end
        tests_run++; if (pix_bytes(40, 9) !== 16'h00FF) begin tests_failed++; $display("FAIL bar_x40 got %h want 00ff", pix_bytes(40, 9)); end
        tests_run++; if (pix_bytes(159, 7) !== 16'h0000) begin tests_failed++; $display("FAIL bar_x159 got %h want 0000", pix_bytes(159, 7)); end
        tests_run++; if (pix_bytes(19, 8) !== 16'h0FFF) begin tests_failed++; $display("FAIL bar_x19_late got %h want 0fff", pix_bytes(19, 8)); end
    endtask

    task automatic test_checker_en_drop;
        int fdc, bad;
        capture_frame(2'd2, 1'b1);
        tests_run++; if (pix_bytes(0, 0) !== 16'h0000) begin tests_failed++; $display("FAIL chk_0_0 got %h want 0000", pix_bytes(0, 0)); end
        tests_run++; if (pix_bytes(8, 0) !== 16'h0FFF) begin tests_failed++; $display("FAIL chk_8_0 got %h want 0fff", pix_bytes(8, 0)); end
        tests_run++; if (pix_bytes(8, 8) !== 16'h0000) begin tests_failed++; $display("FAIL chk_8_8 got %h want 0000", pix_bytes(8, 8)); end
        tests_run++; if (pix_bytes(0, 9) !== 16'h0FFF) begin tests_failed++; $display("FAIL chk_0_9 got %h want 0fff", pix_bytes(0, 9)); end
        tests_run++; if (cap_lines != TB_V) begin tests_failed++; $display("FAIL endrop_lines got %0d want %0d", cap_lines, TB_V); end
        tests_run++; if (cap_periods != FRAME_P) begin tests_failed++; $display("FAIL endrop_period got %0d want %0d", cap_periods, FRAME_P); end
        tests_run++; if (cap_fd_clks != 1) begin tests_failed++; $display("FAIL endrop_frame_done got %0d want 1", cap_fd_clks); end
        bad = 0;
        if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0) bad++;
        repeat (5) begin
            pstep(fdc);
            if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0 || fdc != 0) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL idle_after_drop got %0d active samples want 0", bad); end
        en = 1'b1;
        @(negedge clk);
        tests_run++; if (CAM_vsync !== 1'b1) begin tests_failed++; $display("FAIL restart_vsync got %b want 1", CAM_vsync); end
    endtask

    task automatic test_reset_mid_line;
        int g, fdc, bad;
        g = 0;
        while (CAM_href !== 1'b1 && g < 100) begin
            pstep(fdc);
            g++;
        end
        tests_run++; if (CAM_href !== 1'b1) begin tests_failed++; $display("FAIL midline_href got %b want 1", CAM_href); end
        #3 rst = 1'b0;
        #1;
        tests_run++; if (CAM_href !== 1'b0) begin tests_failed++; $display("FAIL arst_href got %b want 0", CAM_href); end
        tests_run++; if (CAM_D !== 8'h00) begin tests_failed++; $display("FAIL arst_data got %h want 00", CAM_D); end
        tests_run++; if (CAM_pclk !== 1'b0) begin tests_failed++; $display("FAIL arst_pclk got %b want 0", CAM_pclk); end
        tests_run++; if (CAM_vsync !== 1'b0 || frame_done !== 1'b0) begin tests_failed++; $display("FAIL arst_vsync_fd got %b%b want 00", CAM_vsync, frame_done); end
        #3;
        en = 1'b0; mode = 2'd0;
        rst = 1'b1;
        fc_model = 0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (CAM_vsync !== 1'b0) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL post_rst_vsync got %0d high samples want 0", bad); end
        en = 1'b1;
        capture_frame(2'd0, 1'b0);
        tests_run++; if (pix_bytes(0, 0) !== 16'h0000) begin tests_failed++; $display("FAIL post_rst_0_0 got %h want 0000", pix_bytes(0, 0)); end
        tests_run++; if (pix_bytes(5, 3) !== 16'h0008) begin tests_failed++; $display("FAIL post_rst_5_3 got %h want 0008", pix_bytes(5, 3)); end
        tests_run++; if (cap_periods != FRAME_P) begin tests_failed++; $display("FAIL post_rst_period got %0d want %0d", cap_periods, FRAME_P); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        fc_model = 0;
        rst = 1'b0;
        en = 1'b0;
        mode = 2'd0;
        test_reset;
        test_solid;
        test_incr;
        test_bars;
        test_checker_en_drop;
        test_reset_mid_line;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
